led_arbiter: RTL and testbench

LED_ARBITER -- requirements
Module: led_arbiter

---
 rtl/led_arbiter.sv | 124 ++++++++++++
 tb/tb_led_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_arbiter.sv
// led_arbiter: round-robin arbiter granting 3 requesters timed LED ownership.
// Optional LED_ROTATE_EN: rotate the owned pattern left on each non-final tick.
module led_arbiter #(
  parameter int unsigned CLK_DIV      = 13500000,
  parameter int unsigned HOLD_TICKS   = 4,
  parameter logic [2:0]  IDLE_PATTERN = 3'b111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [2:0] pat0,
  input  logic [2:0] pat1,
  input  logic [2:0] pat2,
  output logic [2:0] gnt,
  output logic [2:0] done,
  output logic [2:0] led,
  output logic       busy
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TW = $clog2(HOLD_TICKS + 1);
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TLAST = TW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RELEASE
  } state_t;

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [TW-1:0] ticks_q;
  logic [1:0]    last_q;
  logic [2:0]    gnt_q;
  logic [2:0]    done_q;
  logic [2:0]    led_q;

  logic       tick;
  logic [1:0] s0, s1, s2;
  logic [1:0] win_d;
  logic [2:0] pat_d;

  assign tick = (presc_q == PMAX);

  // Search order starts just after the previous winner.
  always_comb begin
    s0 = 2'd0;
    s1 = 2'd1;
    s2 = 2'd2;
    unique case (last_q)
      2'd0: begin s0 = 2'd1; s1 = 2'd2; s2 = 2'd0; end
      2'd1: begin s0 = 2'd2; s1 = 2'd0; s2 = 2'd1; end
      default: begin s0 = 2'd0; s1 = 2'd1; s2 = 2'd2; end
    endcase
    win_d = s2;
    if (req[s0])      win_d = s0;
    else if (req[s1]) win_d = s1;
    unique case (win_d)
      2'd0:    pat_d = pat0;
      2'd1:    pat_d = pat1;
      default: pat_d = pat2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      ticks_q <= '0;
      last_q  <= 2'd2;
      gnt_q   <= '0;
      done_q  <= '0;
      led_q   <= IDLE_PATTERN;
    end else begin
      done_q  <= '0;
      presc_q <= tick ? '0 : presc_q + PW'(1);
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= HOLD;
            gnt_q   <= 3'b001 << win_d;
            led_q   <= pat_d;
            last_q  <= win_d;
            presc_q <= '0;
            ticks_q <= '0;
          end
        end
        HOLD: begin
          // Completion outranks an abort landing on the same edge.
          if (tick && ticks_q == TLAST) begin
            state_q <= RELEASE;
            gnt_q   <= '0;
            done_q  <= gnt_q;
            led_q   <= IDLE_PATTERN;
          end else if (!req[last_q]) begin
            state_q <= RELEASE;
            gnt_q   <= '0;
            led_q   <= IDLE_PATTERN;
          end else if (tick) begin
            ticks_q <= ticks_q + TW'(1);
`ifdef LED_ROTATE_EN
            led_q   <= {led_q[1:0], led_q[2]};
`else
            led_q   <= led_q;
`endif
          end
        end
        RELEASE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign led  = led_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_led_arbiter.sv
// tb_led_arbiter: directed and random checks of led_arbiter against a
// grant-level reference model (owner, elapsed cycles, release slot).
module tb_led_arbiter;

  localparam int DIV = 4;
  localparam int HT  = 2;
  localparam int NCY = DIV * HT;
  localparam logic [2:0] IDLEP = 3'b111;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] pat0, pat1, pat2;
  logic [2:0] gnt, done, led;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int         m_owner;
  int         m_el;
  int         m_rel;
  int         m_last;
  logic [2:0] m_pat;
  logic [2:0] m_done;

  logic [2:0] e_gnt, e_done, e_led;
  logic       e_busy;

  int order[$];
  int gaps[$];
  int zero_run;
  logic [2:0] prev_gnt;

  led_arbiter #(
    .CLK_DIV     (DIV),
    .HOLD_TICKS  (HT),
    .IDLE_PATTERN(IDLEP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .pat0 (pat0),
    .pat1 (pat1),
    .pat2 (pat2),
    .gnt  (gnt),
    .done (done),
    .led  (led),
    .busy (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [2:0] rotl(input logic [2:0] p, input int n);
    logic [2:0] r;
    r = p;
    for (int i = 0; i < n; i++) r = {r[1:0], r[2]};
    return r;
  endfunction

  function automatic logic [2:0] pat_of(input int i);
    if (i == 0) return pat0;
    if (i == 1) return pat1;
    return pat2;
  endfunction

  task automatic model_edge();
    int idx;
    m_done = 3'b000;
    if (!rst_n) begin
      m_owner = -1;
      m_el    = 0;
      m_rel   = 0;
      m_last  = 2;
    end else if (m_owner >= 0) begin
      if (m_el + 1 == NCY) begin
        m_done  = 3'b001 << m_owner;
        m_owner = -1;
        m_rel   = 1;
      end else if (!req[m_owner]) begin
        m_owner = -1;
        m_rel   = 1;
      end else begin
        m_el++;
      end
    end else if (m_rel != 0) begin
      m_rel = 0;
    end else if (req != 3'b000) begin
      for (int k = 1; k <= 3; k++) begin
        idx = (m_last + k) % 3;
        if (req[idx] && m_owner < 0) m_owner = idx;
      end
      m_last = m_owner;
      m_el   = 0;
      m_pat  = pat_of(m_owner);
    end
    e_gnt  = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
    e_done = m_done;
    e_busy = (m_owner >= 0) || (m_rel != 0);
`ifdef LED_ROTATE_EN
    e_led  = (m_owner >= 0) ? rotl(m_pat, m_el / DIV) : IDLEP;
`else
    e_led  = (m_owner >= 0) ? m_pat : IDLEP;
`endif
  endtask

  task automatic check(input string tag, input logic [2:0] obs,
                       input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("gnt", gnt, e_gnt);
    check("done", done, e_done);
    check("led", led, e_led);
    check("busy", {2'b00, busy}, {2'b00, e_busy});
    if (gnt != 3'b000 && prev_gnt == 3'b000) begin
      order.push_back(gnt == 3'b001 ? 0 : (gnt == 3'b010 ? 1 : 2));
      gaps.push_back(zero_run);
    end
    zero_run = (gnt == 3'b000) ? zero_run + 1 : 0;
    prev_gnt = gnt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 3'b000;
    pat0  = 3'b110;
    pat1  = 3'b110;
    pat2  = 3'b011;
    m_owner = -1; m_el = 0; m_rel = 0; m_last = 2;
    m_pat = IDLEP; m_done = 3'b000;
    zero_run = 0;
    prev_gnt = 3'b000;

    // reset state
    step();
    step();
    rst_n = 1'b1;
    step();

    // single requester, full grant
    req = 3'b001;
    pat0 = 3'b110;
    step();
    check("first_gnt", gnt, 3'b001);
    check("first_led", led, 3'b110);
    for (int i = 0; i < NCY - 1; i++) step();
    req = 3'b000;
    step();
    check("first_done", done, 3'b001);
    check("first_led_rel", led, IDLEP);
    for (int i = 0; i < 3; i++) step();

    // all requesting: order and gaps
    do_reset();
    order.delete();
    gaps.delete();
    req = 3'b111;
    pat1 = 3'b110;
    for (int i = 0; i < 4 * (NCY + 2) + 2; i++) step();
    check("rr_n", 3'(order.size() >= 4 ? 4 : order.size()), 3'd4);
    if (order.size() >= 4) begin
      check("rr0", 3'(order[0]), 3'd0);
      check("rr1", 3'(order[1]), 3'd1);
      check("rr2", 3'(order[2]), 3'd2);
      check("rr3", 3'(order[3]), 3'd0);
      for (int i = 1; i < 4; i++) check("rr_gap", 3'(gaps[i]), 3'd2);
    end
    req = 3'b000;
    for (int i = 0; i < 3; i++) step();

    // requester 1 alone (led rotation when enabled)
    req = 3'b010;
    for (int i = 0; i < NCY + 1; i++) step();
    req = 3'b000;
    for (int i = 0; i < 3; i++) step();

    // abort: req0 drops after 3 cycles, requester 1 pending wins next
    do_reset();
    req = 3'b011;
    step();
    for (int i = 0; i < 2; i++) step();
    req = 3'b010;
    step();
    check("abort_gnt", gnt, 3'b000);
    check("abort_done", done, 3'b000);
    step();
    step();
    check("abort_next", gnt, 3'b010);
    for (int i = 0; i < NCY + 2; i++) step();
    req = 3'b000;
    for (int i = 0; i < 3; i++) step();

    // reset mid-hold
    req = 3'b100;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    check("rst_gnt", gnt, 3'b000);
    check("rst_led", led, IDLEP);
    rst_n = 1'b1;
    req = 3'b111;
    step();
    check("rst_first", gnt, 3'b001);
    req = 3'b000;
    for (int i = 0; i < 3; i++) step();

    // pattern change during hold, drop on final tick
    do_reset();
    req = 3'b001;
    pat0 = 3'b101;
    step();
    for (int i = 0; i < NCY - 1; i++) begin
      pat0 = 3'($urandom_range(0, 7));
      step();
    end
    req = 3'b000;
    step();
    check("final_drop_done", done, 3'b001);
    for (int i = 0; i < 3; i++) step();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) pat0 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) pat1 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) pat2 = 3'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 150) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
